div_sched: RTL and testbench

DIV_SCHED -- requirements
Module: div_sched

---
 rtl/div_sched_if.sv | 28 ++
 rtl/div_sched.sv | 163 ++++++++++++++++
 tb/tb_div_sched.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/div_sched_if.sv
// Request/grant and result bundle for the shared signed-magnitude divider.
interface div_sched_if;
  logic       req_a;
  logic       req_b;
  logic [2:0] num_a;
  logic [2:0] den_a;
  logic [2:0] num_b;
  logic [2:0] den_b;
  logic       gnt_a;
  logic       gnt_b;
  logic       busy;
  logic       owner;
  logic       done;
  logic [4:0] quotient;
  logic [4:0] remainder;
  logic       divbyzero;
  logic       zero;

  modport master (
    output req_a, req_b, num_a, den_a, num_b, den_b,
    input  gnt_a, gnt_b, busy, owner, done, quotient, remainder, divbyzero, zero
  );

  modport slave (
    input  req_a, req_b, num_a, den_a, num_b, den_b,
    output gnt_a, gnt_b, busy, owner, done, quotient, remainder, divbyzero, zero
  );
endinterface

// File: rtl/div_sched.sv
// Two-requester arbiter in front of a repeated-subtraction divider on
// 2-bit signed-magnitude operands.
//
// state | meaning
// IDLE  | waiting for a request; winner chosen and operands latched on exit
// SUB   | one compare/subtract per cycle on the latched magnitudes
// DONE  | result registers loaded, done pulse visible, back to IDLE next
module div_sched #(
  parameter bit FAIR = 1'b1
) (
  input logic       clk,
  input logic       rst,
  div_sched_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic       load;
  logic       step;
  logic       finish;
  logic       dbz;
  logic       pick_b;
  logic       prefer_b_q;
  logic [2:0] sel_num;
  logic [2:0] sel_den;

  logic [1:0] rem_q;
  logic [1:0] den_q;
  logic [1:0] quo_q;
  logic       num_sgn_q;
  logic       den_sgn_q;

  logic       gnt_a_q;
  logic       gnt_b_q;
  logic       busy_q;
  logic       owner_q;
  logic       done_q;
  logic [4:0] quo_out_q;
  logic [4:0] rem_out_q;
  logic       dbz_q;
  logic       zero_q;

  // On a tie, B only wins in fair mode when it was not served last.
  always_comb begin
    pick_b = bus.req_b & (~bus.req_a | ((FAIR != 1'b0) & prefer_b_q));
  end

  assign sel_num = pick_b ? bus.num_b : bus.num_a;
  assign sel_den = pick_b ? bus.den_b : bus.den_a;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    dbz     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_a | bus.req_b) begin
          load    = 1'b1;
          state_d = SUB;
        end
      end
      SUB: begin
        if (den_q == 2'd0) begin
          dbz     = 1'b1;
          finish  = 1'b1;
          state_d = DONE;
        end else if (rem_q >= den_q) begin
          step = 1'b1;
        end else begin
          finish  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q      <= 2'd0;
      den_q      <= 2'd0;
      quo_q      <= 2'd0;
      num_sgn_q  <= 1'b0;
      den_sgn_q  <= 1'b0;
      prefer_b_q <= 1'b0;
      gnt_a_q    <= 1'b0;
      gnt_b_q    <= 1'b0;
      busy_q     <= 1'b0;
      owner_q    <= 1'b0;
      done_q     <= 1'b0;
      quo_out_q  <= 5'd0;
      rem_out_q  <= 5'd0;
      dbz_q      <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      gnt_a_q <= load & ~pick_b;
      gnt_b_q <= load & pick_b;
      done_q  <= finish;

      if (load) begin
        rem_q     <= sel_num[1:0];
        den_q     <= sel_den[1:0];
        quo_q     <= 2'd0;
        num_sgn_q <= sel_num[2];
        den_sgn_q <= sel_den[2];
        owner_q   <= pick_b;
        busy_q    <= 1'b1;
        if (FAIR != 1'b0) begin
          prefer_b_q <= ~pick_b;
        end
      end

      // rem >= den guarantees no underflow, and at most 3 steps fit in 2 bits.
      if (step) begin
        rem_q <= rem_q - den_q;
        quo_q <= quo_q + 2'd1;
      end

      if (finish) begin
        quo_out_q <= {num_sgn_q ^ den_sgn_q, 2'b00, (dbz ? 2'd0 : quo_q)};
        rem_out_q <= {num_sgn_q, 2'b00, (dbz ? 2'd0 : rem_q)};
        dbz_q     <= dbz;
        zero_q    <= dbz | (rem_q == 2'd0);
      end

      if (state_q == DONE) begin
        busy_q <= 1'b0;
      end
    end
  end

  assign bus.gnt_a     = gnt_a_q;
  assign bus.gnt_b     = gnt_b_q;
  assign bus.busy      = busy_q;
  assign bus.owner     = owner_q;
  assign bus.done      = done_q;
  assign bus.quotient  = quo_out_q;
  assign bus.remainder = rem_out_q;
  assign bus.divbyzero = dbz_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_div_sched.sv
// Directed bench for div_sched: scoreboarded divisions, arbitration order,
// reset abort and result hold.
module tb_div_sched;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  div_sched_if bus ();
  div_sched_if bus_fp ();

  div_sched #(.FAIR(1'b1)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  div_sched #(.FAIR(1'b0)) dut_fp (
    .clk(clk),
    .rst(rst),
    .bus(bus_fp.slave)
  );

  typedef struct {
    logic [4:0] q;
    logic [4:0] r;
    logic       dbz;
    logic       zero;
    logic       own;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   gcyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division on magnitudes, sign rules applied after.
  function automatic exp_t model(input logic [2:0] num, input logic [2:0] den, input logic own);
    exp_t e;
    int   nm, dm, qm, rm;
    nm = int'(num[1:0]);
    dm = int'(den[1:0]);
    if (dm == 0) begin
      qm = 0; rm = 0; e.dbz = 1'b1; e.lat = 2;
    end else begin
      qm = nm / dm; rm = nm % dm; e.dbz = 1'b0; e.lat = qm + 2;
    end
    e.q    = {num[2] ^ den[2], 2'b00, 2'(qm)};
    e.r    = {num[2], 2'b00, 2'(rm)};
    e.zero = (rm == 0);
    e.own  = own;
    return e;
  endfunction

  task automatic start(input logic b, input logic [2:0] num, input logic [2:0] den);
    sb.push_back(model(num, den, b));
    @(negedge clk);
    if (b) begin
      bus.req_b = 1'b1; bus.num_b = num; bus.den_b = den;
    end else begin
      bus.req_a = 1'b1; bus.num_a = num; bus.den_a = den;
    end
    gcyc = 0;
    do begin
      @(negedge clk);
      gcyc++;
    end while (!(b ? bus.gnt_b : bus.gnt_a) && gcyc < 10);
    check("gnt_cycle", gcyc, 1);
    check("owner_at_gnt", bus.owner, b);
    check("busy_at_gnt", bus.busy, 1);
    if (b) bus.req_b = 1'b0;
    else   bus.req_a = 1'b0;
  endtask

  task automatic finish_op();
    exp_t e;
    check("sb_nonempty", sb.size() > 0, 1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    while (!bus.done && gcyc < 12) begin
      @(negedge clk);
      gcyc++;
      if (gcyc == 2) check("gnt_one_cycle", bus.gnt_a | bus.gnt_b, 0);
    end
    check("done_cycle", gcyc, e.lat);
    check("quotient", bus.quotient, e.q);
    check("remainder", bus.remainder, e.r);
    check("divbyzero", bus.divbyzero, e.dbz);
    check("zero", bus.zero, e.zero);
    check("owner_at_done", bus.owner, e.own);
    check("busy_at_done", bus.busy, 1);
    @(negedge clk);
    check("busy_after_done", bus.busy, 0);
    check("done_pulse", bus.done, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"}, {bus.gnt_a, bus.gnt_b}, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_owner"}, bus.owner, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_quotient"}, bus.quotient, 0);
    check({tag, "_remainder"}, bus.remainder, 0);
    check({tag, "_dbz_zero"}, {bus.divbyzero, bus.zero}, 0);
  endtask

  initial begin
    logic exp_fair [3] = '{1'b0, 1'b1, 1'b0};
    int   idx, idx_fp;

    rst = 1'b1;
    {bus.req_a, bus.req_b, bus.num_a, bus.den_a, bus.num_b, bus.den_b} = '0;
    {bus_fp.req_a, bus_fp.req_b, bus_fp.num_a, bus_fp.den_a, bus_fp.num_b, bus_fp.den_b} = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    start(1'b0, 3'b011, 3'b010);
    finish_op();
    start(1'b1, 3'b110, 3'b100);
    finish_op();
    start(1'b0, 3'b111, 3'b001);
    finish_op();

    repeat (3) @(negedge clk);
    check("hold_quotient", bus.quotient, 5'b10011);
    check("hold_remainder", bus.remainder, 5'b10000);
    check("hold_zero", bus.zero, 1);

    start(1'b1, 3'b101, 3'b011);
    finish_op();
    start(1'b0, 3'b010, 3'b110);
    finish_op();
    start(1'b1, 3'b111, 3'b111);
    finish_op();
    start(1'b0, 3'b011, 3'b000);
    finish_op();

    // B raised while A is mid-operation must wait for A to finish.
    start(1'b0, 3'b111, 3'b001);
    bus.req_b = 1'b1; bus.num_b = 3'b010; bus.den_b = 3'b011;
    sb.push_back(model(3'b010, 3'b011, 1'b1));
    finish_op();
    check("late_b_not_yet", bus.gnt_b, 0);
    @(negedge clk);
    check("late_b_gnt", bus.gnt_b, 1);
    check("late_b_owner", bus.owner, 1);
    gcyc = 1;
    bus.req_b = 1'b0;
    finish_op();

    // Abort a B operation in its second SUB cycle.
    start(1'b1, 3'b111, 3'b001);
    void'(sb.pop_back());
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_all_zero("abort");
    repeat (3) begin
      @(negedge clk);
      check("abort_no_done", bus.done, 0);
    end
    rst = 1'b0;
    start(1'b0, 3'b110, 3'b011);
    finish_op();

    // Arbitration with both requests held high from reset.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.num_a = 3'b001; bus.den_a = 3'b001; bus.num_b = 3'b001; bus.den_b = 3'b001;
    bus_fp.num_a = 3'b001; bus_fp.den_a = 3'b001; bus_fp.num_b = 3'b001; bus_fp.den_b = 3'b001;
    bus.req_a = 1'b1; bus.req_b = 1'b1;
    bus_fp.req_a = 1'b1; bus_fp.req_b = 1'b1;
    idx = 0;
    idx_fp = 0;
    for (int c = 0; c < 60 && (idx < 3 || idx_fp < 3); c++) begin
      @(negedge clk);
      if ((bus.gnt_a | bus.gnt_b) && idx < 3) begin
        check("fair_gnt_b", bus.gnt_b, exp_fair[idx]);
        check("fair_gnt_a", bus.gnt_a, !exp_fair[idx]);
        check("fair_owner", bus.owner, exp_fair[idx]);
        idx++;
      end
      if ((bus_fp.gnt_a | bus_fp.gnt_b) && idx_fp < 3) begin
        check("fixed_gnt_a", {bus_fp.gnt_a, bus_fp.gnt_b}, 2'b10);
        check("fixed_owner", bus_fp.owner, 0);
        idx_fp++;
      end
    end
    check("fair_grant_count", idx, 3);
    check("fixed_grant_count", idx_fp, 3);
    bus.req_a = 1'b0; bus.req_b = 1'b0;
    bus_fp.req_a = 1'b0; bus_fp.req_b = 1'b0;
    repeat (6) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
